cpu_ifetch: RTL and testbench
=============================

// Module: cpu_ifetch
// PURPOSE
//  Instruction-fetch stage directly upstream of cpu_top decode/regfile/ALU datapath.
//  Owns the PC. Issues one word read to instruction memory over a req/ack handshake.
//  Presents {pc, instr} to decode through a valid/ready output register.
//  Accepts branch/jump redirects and guarantees no wrong-path instruction reaches decode.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset
//  ADDR_W    32             PC / imem address width
//  INSTR_W   32             instruction word width
// PORTS
//  CLK             in   1        clock, all state updates on posedge
//  RST             in   1        synchronous, active-high reset
//  imem_req        out  1        fetch request; held high with stable imem_addr until ack
//  imem_addr       out  ADDR_W   word-aligned fetch address
//  imem_ack        in   1        read data valid; may be asserted in the same cycle as req (0-wait)
//  imem_rdata      in   INSTR_W  instruction word, sampled only when imem_req && imem_ack
//  redirect_valid  in   1        1-cycle pulse: taken branch/jump
//  redirect_pc     in   ADDR_W   redirect target; bits[1:0] ignored (forced to 0)
//  out_valid       out  1        {out_pc, out_instr} valid for decode
//  out_ready       in   1        decode accepts; transfer when out_valid && out_ready
//  out_pc          out  ADDR_W   PC of out_instr
//  out_instr       out  INSTR_W  fetched instruction
// BEHAVIOUR
//  Reset: pc=RESET_PC; state=S_FETCH; discard=0; imem_req=0; out_valid=0; out_pc=0; out_instr=0.
//  Cycle after RST deasserts: imem_req=1, imem_addr=RESET_PC.
//  FSM (registered state, Moore outputs):
//   S_FETCH: imem_req=1, imem_addr=pc.
//    On ack: if discard, drop data, clear discard, stay in S_FETCH.
//    Otherwise load out_pc=pc and out_instr=imem_rdata, set out_valid, pc+=4, go to S_HOLD.
//   S_HOLD: imem_req=0; out_valid=1, outputs stable until transfer.
//    On out_ready: out_valid=0 next cycle, go to S_FETCH.
//  Peak throughput 1 instruction per 2 cycles with 0-wait memory. Each extra wait cycle adds 1.
//  Redirect (highest priority, any state), effective next cycle: pc=redirect_pc & ~3, out_valid=0.
//   In S_HOLD: drop the held instruction even if out_ready is high the same cycle; go to S_FETCH.
//   In S_FETCH, no ack this cycle: the request is in flight and cannot be withdrawn.
//    imem_addr stays at the old address until ack; set discard; go to S_FETCH.
//   In S_FETCH, ack this cycle: the data is dropped; the next request uses the redirect target.
//   Second redirect while discard=1: latest target wins; discard stays 1.
//  pc+4 wraps modulo 2^ADDR_W (32'hFFFF_FFFC -> 0). No trap.
//  imem_addr[1:0] is always 0.
//  RST mid-transaction: imem_req=0 next cycle. The bench memory must abandon the old request.
//  No combinational path from out_ready or imem_ack to imem_req or out_valid.
// STRUCTURE
//  cpu_defs.vh (shared include): RESET_PC default, INSTR_W, ADDR_W, state encodings.
//   State encodings: S_FETCH=1'b0, S_HOLD=1'b1.
//  Single module, with the FSM, PC register and output register inline.
//  No sub-module. The PC increment is a local adder.
//  cpu_top later replaces its direct imem/PC logic with this block.
//   Its decode stage drives out_ready=1 until stalls exist.
// TESTING
//  Reset:
//   RST high 2 cycles -> imem_req=0, out_valid=0.
//   First cycle after release -> imem_req=1, imem_addr=0.
//  0-wait imem with the add/sub program, out_ready=1:
//   out_pc 0,4,8,... every 2nd cycle; out_instr[0]=32'h20020005.
//  Wait states:
//   ack 3 cycles after req -> imem_req/imem_addr held stable for 4 cycles.
//   Exactly one out_valid transfer per ack.
//  Backpressure:
//   out_ready=0 for 5 cycles in S_HOLD -> out_pc/out_instr constant, imem_req=0.
//   Then 1 transfer.
//  Redirect in flight:
//   ack delay 3, redirect_pc=32'h43 pulsed 1 cycle after req -> returned word discarded.
//   Next imem_addr=32'h40; next out_pc=32'h40.
//  Redirect collisions:
//   With ack same cycle -> no out_valid, next addr = target.
//   With out_valid && out_ready -> no transfer counted.
//   RST during wait -> imem_req=0 next cycle, then restart at RESET_PC.

Source files
------------

// File: rtl/cpu_ifetch_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths, reset PC
// and the fetch FSM state encoding.
package cpu_ifetch_pkg;

   localparam int          ADDR_W_DEF   = 32;
   localparam int          INSTR_W_DEF  = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic {
      S_FETCH = 1'b0,
      S_HOLD  = 1'b1
   } state_t;

endpackage

// File: rtl/cpu_ifetch.sv
// Instruction-fetch stage: owns the PC, fetches one word per request from imem
// and hands {pc, instr} to decode, squashing wrong-path fetches on redirect.
module cpu_ifetch
   import cpu_ifetch_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                INSTR_W  = INSTR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic               CLK,
   input  logic               RST,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ADDR_W-1:0]  out_pc,
   output logic [INSTR_W-1:0] out_instr,
   output state_t             fsm_state
);

   // Handshakes: imem transfers on a cycle where imem_req && imem_ack (req and
   // addr held until then); decode transfers where out_valid && out_ready, and
   // the pair is held stable until that happens.

   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                req_q, req_d;
   logic                discard_q, discard_d;
   logic                valid_q, valid_d;
   logic [ADDR_W-1:0]   opc_q, opc_d;
   logic [INSTR_W-1:0]  oinstr_q, oinstr_d;

   logic                fire;
   logic [ADDR_W-1:0]   target;
   logic [ADDR_W-1:0]   pc_inc;

   assign fire   = req_q & imem_ack;
   assign target = redirect_pc & ALIGN_MASK;
   assign pc_inc = pc_q + ADDR_W'(4);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      addr_d    = addr_q;
      req_d     = req_q;
      discard_d = discard_q;
      valid_d   = valid_q;
      opc_d     = opc_q;
      oinstr_d  = oinstr_q;
      case (state_q)
         S_FETCH: begin
            req_d = 1'b1;
            if (redirect_valid) begin
               pc_d    = target;
               valid_d = 1'b0;
               if (fire) begin
                  discard_d = 1'b0;
                  addr_d    = target;
               end else if (req_q) begin
                  // request already issued: keep its address, squash its data
                  discard_d = 1'b1;
               end else begin
                  addr_d = target;
               end
            end else if (fire) begin
               if (discard_q) begin
                  discard_d = 1'b0;
                  addr_d    = pc_q;
               end else begin
                  opc_d    = pc_q;
                  oinstr_d = imem_rdata;
                  valid_d  = 1'b1;
                  pc_d     = pc_inc;
                  req_d    = 1'b0;
                  state_d  = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               pc_d    = target;
               addr_d  = target;
               valid_d = 1'b0;
               req_d   = 1'b1;
               state_d = S_FETCH;
            end else if (out_ready) begin
               valid_d = 1'b0;
               addr_d  = pc_q;
               req_d   = 1'b1;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC & ALIGN_MASK;
         addr_q    <= RESET_PC & ALIGN_MASK;
         req_q     <= 1'b0;
         discard_q <= 1'b0;
         valid_q   <= 1'b0;
         opc_q     <= '0;
         oinstr_q  <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         addr_q    <= addr_d;
         req_q     <= req_d;
         discard_q <= discard_d;
         valid_q   <= valid_d;
         opc_q     <= opc_d;
         oinstr_q  <= oinstr_d;
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = addr_q;
   assign out_valid = valid_q;
   assign out_pc    = opc_q;
   assign out_instr = oinstr_q;
   assign fsm_state = state_q;

endmodule

// File: tb/tb_cpu_ifetch.sv
// Self-checking bench for cpu_ifetch: wait-state imem model, directed corner
// cases and a randomized phase checked against a delivered-PC stream model.
module tb_cpu_ifetch;
   import cpu_ifetch_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   state_t      fsm_state;

   always #5 CLK = ~CLK;

   cpu_ifetch #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(RESET_PC)) dut (
      .CLK(CLK), .RST(RST),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instr(out_instr),
      .fsm_state(fsm_state)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // add/sub program at address 0; other addresses return an address hash
   logic [31:0] prog [8] = '{32'h20020005, 32'h2003000c, 32'h00432020, 32'h00822822,
                             32'h20060001, 32'h00c53820, 32'h00e64022, 32'h1000fff9};

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a < 32'd32) return prog[a[4:2]];
      return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0000;
   endfunction

   // imem model and reference state
   int          mem_delay = 0;
   bit          busy = 0;
   int          cnt = 0;
   int          req_run = 0;
   int          last_req_run = 0;
   bit          pend = 0;
   logic [31:0] pend_addr = '0;
   bit          fire_now = 0;
   bit          xfer_now = 0;
   int          n_xfer = 0;
   int          n_fire_plain = 0;
   int          cyc = 0;
   logic [31:0] ref_pc = RESET_PC;

   task automatic next_cycle();
      @(negedge CLK);
      cyc++;
      if (pend) begin
         check_eq("req_held", imem_req, 1);
         check_eq("addr_held", imem_addr, pend_addr);
      end
      if (imem_req === 1'b1) check_eq("addr_align", imem_addr[1:0], 0);
   endtask

   task automatic drive(input bit rst, input bit rdy, input bit rv, input logic [31:0] tgt);
      RST = rst;
      out_ready = rdy;
      redirect_valid = rv;
      redirect_pc = tgt;
      if (imem_req !== 1'b1) begin
         busy = 0;
         imem_ack = 1'b0;
      end else begin
         if (!busy) begin
            busy = 1;
            cnt = (mem_delay < 0) ? $urandom_range(0, 3) : mem_delay;
         end
         if (cnt == 0) begin
            imem_ack = 1'b1;
            imem_rdata = mem_word(imem_addr);
         end else begin
            imem_ack = 1'b0;
            imem_rdata = $urandom;
            cnt--;
         end
      end
      if (imem_req === 1'b1) req_run++;
      else req_run = 0;
      fire_now = (imem_req === 1'b1) && imem_ack && !rst;
      if (fire_now) begin
         busy = 0;
         last_req_run = req_run;
         req_run = 0;
         if (!rv) n_fire_plain++;
      end
      if (rst) begin
         busy = 0;
         req_run = 0;
      end
      pend = (imem_req === 1'b1) && !imem_ack && !rst;
      pend_addr = imem_addr;
      // delivered stream: consecutive words from the last reset/redirect target
      xfer_now = 0;
      if (rst) ref_pc = RESET_PC;
      else if (rv) ref_pc = {tgt[31:2], 2'b00};
      else if (out_valid === 1'b1 && rdy) begin
         xfer_now = 1;
         n_xfer++;
         check_eq("xfer_pc", out_pc, ref_pc);
         check_eq("xfer_instr", out_instr, mem_word(ref_pc));
         ref_pc += 32'd4;
      end
   endtask

   task automatic run_until_xfer(input string tag, input logic [31:0] exp_pc);
      bit got = 0;
      for (int i = 0; i < 30 && !got; i++) begin
         next_cycle();
         if (out_valid === 1'b1) check_eq({tag, "_pc"}, out_pc, exp_pc);
         drive(0, 1, 0, 0);
         got = xfer_now;
      end
      check_eq({tag, "_seen"}, got, 1);
   endtask

   task automatic wait_valid(input bit rdy);
      bit got = 0;
      for (int i = 0; i < 30; i++) begin
         next_cycle();
         if (out_valid === 1'b1) begin
            got = 1;
            break;
         end
         drive(0, rdy, 0, 0);
      end
      check_eq("wait_valid", got, 1);
   endtask

   task automatic wait_fresh_req(input int age);
      bit got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         next_cycle();
         drive(0, 1, 0, 0);
         got = (imem_req === 1'b1) && (req_run == age) && !fire_now;
      end
      check_eq("wait_req", got, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int last_cyc;
      int cnt_x;
      int x0;
      int f0;
      bit got;

      // reset
      mem_delay = 0;
      next_cycle(); drive(1, 1, 0, 0);
      next_cycle();
      check_eq("rst_req", imem_req, 0);
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_out_pc", out_pc, 0);
      check_eq("rst_out_instr", out_instr, 0);
      check_eq("rst_state", fsm_state, S_FETCH);
      drive(1, 1, 0, 0);
      next_cycle(); drive(0, 1, 0, 0);
      next_cycle();
      check_eq("first_req", imem_req, 1);
      check_eq("first_addr", imem_addr, RESET_PC);
      drive(0, 1, 0, 0);

      // 0-wait, full throughput: one transfer every 2 cycles
      cnt_x = 0;
      last_cyc = 0;
      for (int i = 0; i < 19; i++) begin
         next_cycle();
         drive(0, 1, 0, 0);
         if (xfer_now) begin
            if (cnt_x == 0) begin
               check_eq("first_pc", out_pc, 32'h0);
               check_eq("first_instr", out_instr, 32'h20020005);
            end else begin
               check_eq("xfer_spacing", cyc - last_cyc, 2);
            end
            last_cyc = cyc;
            cnt_x++;
         end
      end
      check_eq("zw_count", cnt_x, 10);

      // wait states: 3-cycle ack delay, one transfer per ack
      mem_delay = 3;
      x0 = n_xfer;
      f0 = n_fire_plain;
      for (int i = 0; i < 40; i++) begin
         next_cycle();
         drive(0, 1, 0, 0);
         if (fire_now) check_eq("req_len", last_req_run, 4);
      end
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         next_cycle();
         drive(0, 1, 0, 0);
         got = (out_valid !== 1'b1) && !fire_now;
      end
      check_eq("drain", got, 1);
      check_eq("ack_xfer", n_fire_plain - f0, n_xfer - x0);
      check_eq("ws_progress", (n_xfer - x0) >= 5, 1);

      // backpressure: 5 held cycles, then one transfer
      mem_delay = 0;
      wait_valid(0);
      drive(0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         check_eq("bp_valid", out_valid, 1);
         check_eq("bp_pc", out_pc, ref_pc);
         check_eq("bp_instr", out_instr, mem_word(ref_pc));
         check_eq("bp_req", imem_req, 0);
         check_eq("bp_state", fsm_state, S_HOLD);
         drive(0, 0, 0, 0);
      end
      next_cycle();
      check_eq("bp_release_valid", out_valid, 1);
      drive(0, 1, 0, 0);
      next_cycle();
      check_eq("bp_after_valid", out_valid, 0);
      check_eq("bp_after_req", imem_req, 1);
      drive(0, 1, 0, 0);

      // redirect while a request is in flight
      mem_delay = 3;
      wait_fresh_req(1);
      next_cycle();
      check_eq("inflight_req", imem_req, 1);
      drive(0, 1, 1, 32'h43);
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         next_cycle(); drive(0, 1, 0, 0); got = fire_now;
      end
      check_eq("inflight_ack", got, 1);
      next_cycle();
      check_eq("redir_req", imem_req, 1);
      check_eq("redir_addr", imem_addr, 32'h40);
      check_eq("redir_no_valid", out_valid, 0);
      drive(0, 1, 0, 0);
      run_until_xfer("redir_xfer", 32'h40);

      // two redirects during one in-flight request: latest wins
      wait_fresh_req(1);
      next_cycle(); drive(0, 1, 1, 32'h300);
      next_cycle(); drive(0, 1, 1, 32'h506);
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         next_cycle(); drive(0, 1, 0, 0); got = fire_now;
      end
      next_cycle();
      check_eq("redir2_addr", imem_addr, 32'h504);
      drive(0, 1, 0, 0);
      run_until_xfer("redir2_xfer", 32'h504);

      // redirect in the same cycle as a 0-wait ack
      mem_delay = 0;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         next_cycle();
         if (imem_req === 1'b1 && !busy) begin
            got = 1;
            break;
         end
         drive(0, 1, 0, 0);
      end
      check_eq("ack_redir_found", got, 1);
      drive(0, 1, 1, 32'h100);
      check_eq("ack_redir_ack", imem_ack, 1);
      next_cycle();
      check_eq("ack_redir_valid", out_valid, 0);
      check_eq("ack_redir_addr", imem_addr, 32'h100);
      check_eq("ack_redir_req", imem_req, 1);
      drive(0, 1, 0, 0);
      run_until_xfer("ack_redir_xfer", 32'h100);

      // redirect while decode accepts: held instruction is dropped
      wait_valid(0);
      drive(0, 1, 1, 32'h200);
      next_cycle();
      check_eq("hold_redir_valid", out_valid, 0);
      check_eq("hold_redir_addr", imem_addr, 32'h200);
      check_eq("hold_redir_req", imem_req, 1);
      drive(0, 1, 0, 0);
      run_until_xfer("hold_redir_xfer", 32'h200);

      // PC wraps at the top of the address space
      wait_valid(0);
      drive(0, 1, 1, 32'hFFFF_FFFD);
      run_until_xfer("wrap_hi", 32'hFFFF_FFFC);
      run_until_xfer("wrap_lo", 32'h0);

      // reset while a request waits for its ack
      mem_delay = 3;
      wait_fresh_req(2);
      next_cycle(); drive(1, 1, 0, 0);
      next_cycle();
      check_eq("rst_mid_req", imem_req, 0);
      check_eq("rst_mid_valid", out_valid, 0);
      drive(0, 1, 0, 0);
      next_cycle();
      check_eq("rst_mid_restart_req", imem_req, 1);
      check_eq("rst_mid_restart_addr", imem_addr, RESET_PC);
      drive(0, 1, 0, 0);
      run_until_xfer("rst_mid_xfer", RESET_PC);

      // randomized traffic against the stream model
      mem_delay = -1;
      x0 = n_xfer;
      for (int i = 0; i < 600; i++) begin
         bit          r_rst;
         bit          r_rv;
         bit          r_rdy;
         logic [31:0] r_tgt;
         r_rst = ($urandom_range(0, 199) == 0);
         r_rv  = ($urandom_range(0, 15) == 0);
         r_rdy = ($urandom_range(0, 9) < 7);
         r_tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : 32'($urandom_range(0, 255));
         next_cycle();
         drive(r_rst, r_rdy, r_rv, r_tgt);
      end
      check_eq("rand_progress", (n_xfer - x0) > 50, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
